// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder: fixed-latency reads from a word store with a side-band load port.
// Define IMEM_ALIGN_CHECK_EN to fault on misaligned (req_addr[1:0] != 0) fetches.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_fault,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;
  logic [AW-1:0] r_addr;
  logic          r_fault_pend;
  logic [31:0]   r_store [DEPTH_WORDS];
  logic          r_rsp_valid;
  logic          r_rsp_fault;
  logic [31:0]   r_rsp_instr;

  logic w_accept;
  logic w_capture;
  logic w_release;
  logic w_ready;
  logic w_oor;
  logic w_misalign;

  // Any set bit above the word index means the word index is past the store.
  assign w_oor = |req_addr[31:AW+2];

`ifdef IMEM_ALIGN_CHECK_EN
  assign w_misalign = |req_addr[1:0];
`else
  logic w_unused_align;
  assign w_misalign     = 1'b0;
  assign w_unused_align = ^req_addr[1:0];
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        // rsp_valid is always high here, so rsp_ready alone completes the handshake.
        w_ready = rsp_ready;
        if (rsp_ready) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_accept = req_valid && w_ready;
    if (w_accept) begin
      w_state_next = S_BUSY;
      w_cnt_next   = CNT_INIT;
    end
  end

  assign req_ready = w_ready && rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = r_rsp_instr;
  assign rsp_fault = r_rsp_fault;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr       <= '0;
      r_fault_pend <= 1'b0;
    end else if (w_accept) begin
      r_addr       <= req_addr[AW+1:2];
      r_fault_pend <= w_oor || w_misalign;
    end
  end

  // Reading the array here sees pre-edge contents, so a same-edge load write returns old data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_instr <= 32'h0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_fault <= r_fault_pend;
      r_rsp_instr <= r_fault_pend ? NOP : r_store[r_addr];
    end else if (w_release) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Store has no reset so loaded programs survive a core reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_store[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: expected responses queued at request time, checked on handshake.
module tb_imem_fetch_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_fault;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic prev_valid = 1'b0;

  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];
  int          acc_q [$];

  imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] expect_of(input logic [31:0] a);
    int idx;
    idx = int'(a[31:2]);
    if (idx >= DEPTH) return {1'b1, NOP};
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return {1'b1, NOP};
`endif
    return {1'b0, model[idx]};
  endfunction

  // Monitor: latency from accept to rsp_valid rise, and response contents on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("rsp_without_accept", 32'(rsp_valid), 32'd0);
        else check("latency", 32'(cyc - acc_q.pop_front()), 32'(LAT + 1));
      end
      if (rsp_valid && rsp_ready) begin
        logic [32:0] e;
        check("req_ready_on_hs", 32'(req_ready), 32'd1);
        if (exp_q.size() == 0) begin
          check("rsp_without_req", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("rsp cyc=%0d instr=%h fault=%b exp_instr=%h exp_fault=%b",
                   cyc, rsp_instr, rsp_fault, e[31:0], e[32]);
          check("rsp_instr", rsp_instr, e[31:0]);
          check("rsp_fault", 32'(rsp_fault), 32'(e[32]));
        end
      end
    end
    prev_valid <= rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    model[a] = d;
  endtask

  task automatic send(input logic [31:0] a);
    exp_q.push_back(expect_of(a));
    req_addr  = a;
    req_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (req_ready) break;
      if (n >= 60) begin
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        break;
      end
    end
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    for (int i = 0; i < 8; i++) load(i, 32'h1000_0000 + 32'(i * 32'h0101));
    load(3, 32'h0050_0093);
    load(255, 32'hCAFE_F00D);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_instr", rsp_instr, 32'h0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    send(32'h0000_000C);
    wait_drain();

    send(32'h0000_0000);
    send(32'h0000_0004);
    send(32'h0000_0008);
    wait_drain();

    rsp_ready = 1'b0;
    send(32'h0000_000C);
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    repeat (5) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_instr", rsp_instr, model[3]);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_req_ready", 32'(req_ready), 32'd1);
    wait_drain();

    send(32'h0000_0400);
    send(32'h0000_03FC);
    send(32'h0000_0002);
    send(32'hFFFF_FFF0);
    wait_drain();

    send(32'h0000_000C);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    tick();
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    send(32'h0000_000C);
    wait_drain();

    send(32'h0000_000C);
    repeat (LAT - 1) tick();
    load(3, 32'hDEAD_BEEF);
    wait_drain();
    send(32'h0000_000C);
    wait_drain();

    for (int i = 0; i < 6; i++) send({22'h0, $urandom_range(0, 7), 2'b00});
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
